// File: rtl/gf_arith_server_if.sv
// Request/response bundle between the s_box requester lanes and gf_arith_server.
// The master side (lanes) drives requests; the slave side (server) grants and responds.
interface gf_arith_server_if #(
  parameter int NUM_LANES = 4
);
  logic [NUM_LANES-1:0]   req_valid;
  logic [NUM_LANES-1:0]   req_ready;
  logic [2*NUM_LANES-1:0] req_op;
  logic [8*NUM_LANES-1:0] req_a;
  logic [4*NUM_LANES-1:0] req_b;
  logic [NUM_LANES-1:0]   rsp_valid;
  logic [7:0]             rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/gf_arith_server.sv
// Round-robin shared GF(256)/GF(16) arithmetic responder with a 2-stage pipeline.
// Optional per-opcode saturating counters are built when GF_SRV_STATS_EN is defined.
module gf_arith_server #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  gf_arith_server_if.slave bus
`ifdef GF_SRV_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [63:0]      stat_cnt
`endif
);

  localparam logic [1:0] OP_G2F = 2'd0;
  localparam logic [1:0] OP_F2G = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  // Composite-field basis change: output is {q,p}, q in [7:4].
  function automatic logic [7:0] gf256_to_gf16(input logic [7:0] a);
    logic [7:0] y;
    y[7] = a[7] ^ a[5];
    y[6] = a[7] ^ a[6] ^ a[4] ^ a[3] ^ a[2] ^ a[1];
    y[5] = a[7] ^ a[5] ^ a[3] ^ a[2];
    y[4] = a[7] ^ a[5] ^ a[3] ^ a[2] ^ a[1];
    y[3] = a[7] ^ a[6] ^ a[2] ^ a[1];
    y[2] = a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1];
    y[1] = a[6] ^ a[4] ^ a[1];
    y[0] = a[6] ^ a[1] ^ a[0];
    return y;
  endfunction

  function automatic logic [7:0] gf16_to_gf256(input logic [7:0] y);
    logic [7:0] a;
    a[7] = y[7] ^ y[6] ^ y[5] ^ y[1];
    a[6] = y[6] ^ y[2];
    a[5] = y[6] ^ y[5] ^ y[1];
    a[4] = y[6] ^ y[5] ^ y[4] ^ y[2] ^ y[1];
    a[3] = y[5] ^ y[4] ^ y[3] ^ y[2] ^ y[1];
    a[2] = y[7] ^ y[4] ^ y[3] ^ y[2] ^ y[1];
    a[1] = y[5] ^ y[4];
    a[0] = y[6] ^ y[5] ^ y[4] ^ y[2] ^ y[0];
    return a;
  endfunction

  // Carry-less product folded with x^4 = x + 1.
  function automatic logic [3:0] mul_core(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    logic [3:0] r;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ (7'(a) << i);
    end
    r[0] = p[0] ^ p[4];
    r[1] = p[1] ^ p[4] ^ p[5];
    r[2] = p[2] ^ p[5] ^ p[6];
    r[3] = p[3] ^ p[6];
    return r;
  endfunction

  function automatic logic [3:0] mul_b(input logic [3:0] a);
    logic [3:0] y;
    y[0] = a[1] ^ a[2] ^ a[3];
    y[1] = a[0] ^ a[1];
    y[2] = a[0] ^ a[1] ^ a[2];
    y[3] = a[0] ^ a[1] ^ a[2] ^ a[3];
    return y;
  endfunction

  logic [LANE_W-1:0]    ptr_q, ptr_d;
  logic [NUM_LANES-1:0] grant;
  logic [LANE_W-1:0]    gnt_idx;
  logic                 acc;
  logic [1:0]           op_sel;
  logic [7:0]           a_sel;
  logic [3:0]           b_sel;

  logic                 s1_vld_q;
  logic [LANE_W-1:0]    s1_lane_q;
  logic [1:0]           s1_op_q;
  logic [7:0]           s1_a_q;
  logic [3:0]           s1_b_q;
  logic [7:0]           s1_res_d;

  logic [NUM_LANES-1:0] s2_oh_q;
  logic [7:0]           s2_data_q;

  // Arbitration: first valid lane at or after the round-robin pointer.
  always_comb begin
    int idx;
    grant   = '0;
    gnt_idx = '0;
    acc     = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (!acc && bus.req_valid[idx]) begin
        acc        = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = LANE_W'(idx);
      end
    end
  end

  assign bus.req_ready = grant;
  assign op_sel = bus.req_op[2*gnt_idx +: 2];
  assign a_sel  = bus.req_a[8*gnt_idx +: 8];
  assign b_sel  = bus.req_b[4*gnt_idx +: 4];

  always_comb begin
    ptr_d = ptr_q;
    if (acc) begin
      if (gnt_idx == LANE_W'(NUM_LANES - 1)) ptr_d = '0;
      else                                   ptr_d = gnt_idx + LANE_W'(1);
    end
  end

  // Stage 1: capture the granted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      s1_vld_q <= acc;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      s1_lane_q <= gnt_idx;
      s1_op_q   <= op_sel;
      s1_a_q    <= a_sel;
      s1_b_q    <= b_sel;
    end
  end

  always_comb begin
    s1_res_d = '0;
    case (s1_op_q)
      OP_G2F:  s1_res_d = gf256_to_gf16(s1_a_q);
      OP_F2G:  s1_res_d = gf16_to_gf256(s1_a_q);
      OP_MUL:  s1_res_d = {4'h0, mul_core(s1_a_q[3:0], s1_b_q)};
      default: s1_res_d = {4'h0, mul_b(s1_a_q[3:0])};
    endcase
  end

  // Stage 2: result and lane strobe back to the requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_oh_q   <= '0;
      s2_data_q <= '0;
    end else begin
      s2_oh_q <= s1_vld_q ? (NUM_LANES'(1) << s1_lane_q) : '0;
      if (s1_vld_q) s2_data_q <= s1_res_d;
    end
  end

  assign bus.rsp_valid = s2_oh_q;
  assign bus.rsp_data  = s2_data_q;

`ifdef GF_SRV_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (acc) begin
      cnt_q[op_sel] <= sat_inc(cnt_q[op_sel]);
    end
  end

  assign stat_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_gf_arith_server.sv
// Scoreboard bench for gf_arith_server: directed vectors, round-robin model, reset flush.
module tb_gf_arith_server;
  localparam int NL = 4;
  localparam int LW = 2;
  localparam logic [1:0] OP_G2F = 2'd0;
  localparam logic [1:0] OP_F2G = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_MB  = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gf_arith_server_if #(.NUM_LANES(NL)) bus_if ();

`ifdef GF_SRV_STATS_EN
  logic        stat_clr = 1'b0;
  logic [63:0] stat_cnt;
  gf_arith_server #(.NUM_LANES(NL), .LANE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );
`else
  gf_arith_server #(.NUM_LANES(NL), .LANE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave)
  );
`endif

  typedef struct {
    logic [NL-1:0] oh;
    logic [7:0]    data;
    int            due;
  } exp_t;

  exp_t       sbq[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         m_ptr = 0;
  int         rsp_cnt [NL];
  logic [7:0] tb_exp [NL];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Forward basis change built from the images of each input bit.
  function automatic logic [7:0] m_fwd(input logic [7:0] x);
    logic [7:0] cols [8];
    logic [7:0] y;
    cols = '{8'h01, 8'h5F, 8'h7C, 8'h74, 8'h46, 8'hB0, 8'h4B, 8'hFC};
    y = 8'h00;
    for (int i = 0; i < 8; i++) if (x[i]) y = y ^ cols[i];
    return y;
  endfunction

  // Grant model and expected-response producer.
  always @(negedge clk) begin
    int g;
    if (!rst_n) begin
      m_ptr = 0;
      sbq.delete();
    end else if (bus_if.req_valid != '0) begin
      exp_t e;
      g = -1;
      for (int k = 0; k < NL; k++) begin
        if (g < 0 && bus_if.req_valid[(m_ptr + k) % NL]) g = (m_ptr + k) % NL;
      end
      chk("req_ready", bus_if.req_ready, NL'(1) << g);
      e.oh   = NL'(1) << g;
      e.data = tb_exp[g];
      e.due  = cyc + 2;
      sbq.push_back(e);
      m_ptr = (g + 1) % NL;
    end else begin
      chk("req_ready_idle", bus_if.req_ready, 0);
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && bus_if.rsp_valid != '0) begin
      exp_t e;
      for (int k = 0; k < NL; k++) if (bus_if.rsp_valid[k]) rsp_cnt[k]++;
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", bus_if.rsp_valid, 0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_valid", bus_if.rsp_valid, e.oh);
        chk("rsp_data", bus_if.rsp_data, e.data);
        chk("rsp_latency", cyc, e.due);
      end
    end
  end

  task automatic drive1(input int lane, input logic [1:0] op, input logic [7:0] a,
                        input logic [3:0] b, input logic [7:0] exp_data);
    bus_if.req_valid            = '0;
    bus_if.req_valid[lane]      = 1'b1;
    bus_if.req_op[2*lane +: 2]  = op;
    bus_if.req_a[8*lane +: 8]   = a;
    bus_if.req_b[4*lane +: 4]   = b;
    tb_exp[lane]                = exp_data;
    @(posedge clk); #1;
    bus_if.req_valid            = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [1:0] op, input logic [7:0] a,
                          input logic [3:0] b, input logic [7:0] exp_data);
    bus_if.req_op[2*lane +: 2] = op;
    bus_if.req_a[8*lane +: 8]  = a;
    bus_if.req_b[4*lane +: 4]  = b;
    tb_exp[lane]               = exp_data;
  endtask

  initial begin
    int snap [NL];
    bus_if.req_valid = '0;
    bus_if.req_op    = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    for (int k = 0; k < NL; k++) begin
      rsp_cnt[k] = 0;
      tb_exp[k]  = 8'h00;
    end

    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", bus_if.rsp_valid, 0);
    chk("reset_rsp_data", bus_if.rsp_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single MUL on lane 0: x * x^3 = x + 1.
    drive1(0, OP_MUL, 8'h02, 4'h8, 8'h03);
    idle(4);

    // Back-to-back MULB on lane 1.
    drive1(1, OP_MB, 8'h01, 4'h0, 8'h0E);
    drive1(1, OP_MB, 8'h0F, 4'h0, 8'h05);
    idle(4);

    // Forward map of every byte, then map back to the original value.
    for (int x = 0; x < 256; x++) drive1(2, OP_G2F, 8'(x), 4'h0, m_fwd(8'(x)));
    for (int x = 0; x < 256; x++) drive1(2, OP_F2G, m_fwd(8'(x)), 4'h0, 8'(x));
    drive1(2, OP_G2F, 8'h00, 4'h0, 8'h00);
    drive1(2, OP_G2F, 8'h01, 4'h0, 8'h01);
    drive1(2, OP_F2G, 8'h00, 4'h0, 8'h00);
    drive1(2, OP_F2G, 8'h01, 4'h0, 8'h01);
    idle(4);

    // Two requests in flight, then reset before either returns.
    drive1(0, OP_MUL, 8'h02, 4'h8, 8'h03);
    drive1(1, OP_MB, 8'h01, 4'h0, 8'h0E);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_rsp_valid", bus_if.rsp_valid, 0);
    chk("midreset_rsp_data", bus_if.rsp_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postreset_rsp_valid", bus_if.rsp_valid, 0);
    end
    @(posedge clk); #1;

    // All lanes valid for 8 cycles; grant order must restart at lane 0.
    for (int k = 0; k < NL; k++) snap[k] = rsp_cnt[k];
    set_lane(0, OP_MUL, 8'h02, 4'h8, 8'h03);
    set_lane(1, OP_MB,  8'h01, 4'h0, 8'h0E);
    set_lane(2, OP_MB,  8'hFF, 4'hF, 8'h05);
    set_lane(3, OP_MUL, 8'hA3, 4'h3, 8'h05);
    bus_if.req_valid = '1;
    repeat (8) @(posedge clk);
    #1;
    bus_if.req_valid = '0;
    idle(4);
    for (int k = 0; k < NL; k++) chk($sformatf("pulses_lane%0d", k), rsp_cnt[k] - snap[k], 2);

`ifdef GF_SRV_STATS_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("stat_after_reset", stat_cnt, 0);
    drive1(0, OP_MUL, 8'h02, 4'h8, 8'h03);
    drive1(0, OP_MUL, 8'h03, 4'h3, 8'h05);
    drive1(0, OP_MUL, 8'h01, 4'h7, 8'h07);
    drive1(1, OP_MB,  8'h0F, 4'h0, 8'h05);
    chk("stat_mul", stat_cnt[47:32], 3);
    chk("stat_mulb", stat_cnt[63:48], 1);
    chk("stat_map", stat_cnt[31:0], 0);
    stat_clr = 1'b1;
    drive1(0, OP_MUL, 8'h02, 4'h8, 8'h03);
    stat_clr = 1'b0;
    chk("stat_clr_wins", stat_cnt, 0);
    drive1(2, OP_G2F, 8'h01, 4'h0, 8'h01);
    chk("stat_resume", stat_cnt[15:0], 1);
    idle(4);
`endif

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion within 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule
